seq_shift_add_multiplier: RTL

Sequential unsigned shift-and-add multiplier. It computes the product over WIDTH cycles using one shared WIDTH-bit ripple-carry adder built from full_adder cells. It is the area-reduced counterpart to the combinational array multiplier: one adder row, time-multiplexed by a small FSM. Operands enter and the product leaves over valid/ready handshakes.

---
 rtl/seq_shift_add_multiplier_pkg.sv | 19 +
 rtl/seq_shift_add_multiplier_if.sv | 34 +++
 rtl/seq_shift_add_multiplier_adder.sv | 40 ++++
 rtl/seq_shift_add_multiplier.sv | 86 ++++++++
 4 files changed

// File: rtl/seq_shift_add_multiplier_pkg.sv
// rtl/seq_shift_add_multiplier_pkg.sv - shared FSM encoding and sizing helpers for sequential multipliers
package seq_shift_add_multiplier_pkg;

    // Encodings are fixed so other sequential multipliers can decode the same values.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADD_SHIFT = 2'd1,
        DONE      = 2'd2
    } mult_state_e;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;

    // Iteration counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// rtl/seq_shift_add_multiplier_if.sv - operand/product handshake bundle for the sequential multiplier
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    // Requester side: supplies operands, consumes the product.
    modport master (
        output in_valid,
        output multiplicand,
        output multiplier,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product
    );

    // Multiplier side.
    modport slave (
        input  in_valid,
        input  multiplicand,
        input  multiplier,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product
    );
endinterface

// File: rtl/seq_shift_add_multiplier_adder.sv
// rtl/seq_shift_add_multiplier_adder.sv - full_adder cell and the ripple-carry adder chained from it

// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// WIDTH-bit ripple-carry adder; purely combinational.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .sum   (sum[i]),
            .c_out (carry[i+1])
        );
    end

    assign c_out = carry[WIDTH];
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - unsigned shift-and-add multiplier, one shared adder row over WIDTH cycles
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    seq_shift_add_multiplier_if.slave     bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    mult_state_e          state_q;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH-1:0]     a_q;
    logic                 c_q;
    logic [WIDTH-1:0]     q_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 cout;

    // Partial product for this iteration: M when the current multiplier LSB is set.
    assign addend = q_q[0] ? m_q : '0;

    // C is cleared by every shift and by load/reset, so using it as carry-in keeps cin at 0.
    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (a_q),
        .b     (addend),
        .c_in  (c_q),
        .sum   (sum),
        .c_out (cout)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = {a_q, q_q};

    // Control FSM plus the A/Q shift register and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            c_q     <= 1'b0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        m_q     <= bus.multiplicand;
                        q_q     <= bus.multiplier;
                        a_q     <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= CNT_W'(WIDTH - 1);
                        state_q <= ADD_SHIFT;
                    end
                end
                ADD_SHIFT: begin
                    // {C,A,Q} <= {cout,sum,Q} >> 1: the carry becomes A's MSB, sum LSB enters Q.
                    a_q <= {cout, sum[WIDTH-1:1]};
                    q_q <= {sum[0], q_q[WIDTH-1:1]};
                    c_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    // Product registers hold under backpressure and are left intact on exit.
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
